// File: rtl/wam_mole.sv
// wam_mole: whack-a-mole field controller with LFSR spawner, per-hole lifetimes,
// miss counting and a saturating two-digit BCD score.
module wam_mole #(
    parameter int         N_HOLE   = 16,
    parameter int         MISS_MAX = 8,
    parameter logic [7:0] SEED     = 8'hA5
) (
    input  logic              clk_19,
    input  logic              start,
    input  logic              go,
    input  logic              tick,
    input  logic [3:0]        age,
    input  logic [7:0]        rto,
    input  logic [N_HOLE-1:0] hit,
    output logic [N_HOLE-1:0] mole,
    output logic              hit_ok,
    output logic              miss,
    output logic [3:0]        sc0,
    output logic [3:0]        sc1,
    output logic              cout0,
    output logic              over
);
    typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;

    state_t            state_q, state_d;
    logic [7:0]        lfsr_q, lfsr_d;
    logic [N_HOLE-1:0] mole_q, mole_d;
    logic [3:0]        life_q [N_HOLE];
    logic [3:0]        life_d [N_HOLE];
    logic [3:0]        sc0_q, sc0_d, sc1_q, sc1_d, miss_cnt_q, miss_cnt_d;
    logic              hit_ok_q, hit_ok_d, miss_q, miss_d, cout0_q, cout0_d;
    logic [N_HOLE-1:0] hv, hone, spawn_oh;
    logic [3:0]        idx, life_new;
    logic              expired;

    assign idx      = lfsr_q[7:4] ^ lfsr_q[3:0];
    assign life_new = (age == 4'd0) ? 4'd1 : age;
    assign hv       = hit & mole_q;
    // isolate the lowest-index valid hit
    assign hone     = hv & (-hv);
    assign spawn_oh = (tick && lfsr_q < rto) ? (N_HOLE'(1) << idx) : '0;
    assign lfsr_d   = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    always_comb begin
        state_d    = state_q;
        mole_d     = mole_q;
        life_d     = life_q;
        sc0_d      = sc0_q;
        sc1_d      = sc1_q;
        miss_cnt_d = miss_cnt_q;
        hit_ok_d   = 1'b0;
        miss_d     = 1'b0;
        cout0_d    = 1'b0;
        expired    = 1'b0;
        if (state_q != PLAY) begin
            if (go) begin
                state_d    = PLAY;
                mole_d     = '0;
                life_d     = '{default: '0};
                sc0_d      = '0;
                sc1_d      = '0;
                miss_cnt_d = '0;
            end
        end else begin
            // hit beats spawn, spawn beats ageing
            for (int i = 0; i < N_HOLE; i++) begin
                if (hone[i]) begin
                    mole_d[i] = 1'b0;
                    life_d[i] = '0;
                end else if (spawn_oh[i]) begin
                    mole_d[i] = 1'b1;
                    life_d[i] = life_new;
                end else if (tick && mole_q[i]) begin
                    if (life_q[i] == 4'd1) begin
                        mole_d[i] = 1'b0;
                        life_d[i] = '0;
                        expired   = 1'b1;
                    end else begin
                        life_d[i] = life_q[i] - 4'd1;
                    end
                end
            end
            hit_ok_d = |hv;
            if (|hv && !(sc0_q == 4'd9 && sc1_q == 4'd9)) begin
                cout0_d = sc0_q == 4'd9;
                sc0_d   = (sc0_q == 4'd9) ? 4'd0 : sc0_q + 4'd1;
                sc1_d   = (sc0_q == 4'd9) ? sc1_q + 4'd1 : sc1_q;
            end
            miss_d     = expired;
            miss_cnt_d = miss_cnt_q + {3'd0, expired && miss_cnt_q != 4'd15};
            if (miss_cnt_d >= 4'(MISS_MAX)) begin
                state_d = OVER;
                mole_d  = '0;
                life_d  = '{default: '0};
            end
        end
    end

    always_ff @(posedge clk_19) begin
        if (start) begin
            state_q    <= IDLE;
            lfsr_q     <= SEED;
            mole_q     <= '0;
            life_q     <= '{default: '0};
            sc0_q      <= '0;
            sc1_q      <= '0;
            miss_cnt_q <= '0;
            hit_ok_q   <= 1'b0;
            miss_q     <= 1'b0;
            cout0_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            mole_q     <= mole_d;
            life_q     <= life_d;
            sc0_q      <= sc0_d;
            sc1_q      <= sc1_d;
            miss_cnt_q <= miss_cnt_d;
            hit_ok_q   <= hit_ok_d;
            miss_q     <= miss_d;
            cout0_q    <= cout0_d;
        end
    end

    assign mole   = mole_q;
    assign hit_ok = hit_ok_q;
    assign miss   = miss_q;
    assign sc0    = sc0_q;
    assign sc1    = sc1_q;
    assign cout0  = cout0_q;
    assign over   = state_q == OVER;
endmodule
